trial_div_factor: RTL and testbench
===================================

// Module: trial_div_factor
// PURPOSE
//  Sequential, parametrised successor to the combinational small-prime factor finder.
//  Factors an N_W-bit modulus n = p*q by trial division.
//  One candidate at a time goes through a shared serial divider, with a start/busy/done handshake.
//  Covers any n up to 2^N_W-1 with no fixed prime table. Feeds the RSA key-recovery path.
// PARAMETERS
//  N_W    14  width of n, p, q and of the internal divisor/quotient
//  CNT_W  8   width of trials counter; saturates at 2^CNT_W-1
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      request; sampled only while busy=0
//  abort    in   1      synchronous cancel while busy=1
//  n        in   N_W    modulus; captured on the accepted start
//  busy     out  1      high from the cycle after accept until done
//  done     out  1      1-cycle pulse, result valid
//  p        out  N_W    smallest factor >=2; 1 if n is prime
//  q        out  N_W    n/p; n if n is prime
//  prime    out  1      no divisor <= floor(sqrt(n)) found
//  invalid  out  1      n < 2
//  trials   out  CNT_W  candidates tested for this result
// BEHAVIOUR
//  Reset: FSM=IDLE. busy, done, prime and invalid = 0. p, q and trials = 0.
//  FSM states: IDLE, LOAD, DIV, CHECK, FIN.
//   IDLE -> LOAD on start (n<2: IDLE -> FIN). LOAD loads the divider and resets the bit counter.
//   DIV runs exactly N_W cycles, 1 restoring quotient bit per cycle. LOAD -> DIV -> CHECK.
//   CHECK -> FIN when rem==0 or quo<d; otherwise -> LOAD with the next candidate.
//   FIN: done=1 for one cycle, busy=0, -> IDLE.
//  CHECK order: rem==0 first, giving p=d, q=quo, prime=0.
//   Else quo<d (equivalent to d*d>n), giving p=1, q=n, prime=1. No multiplier is used.
//  Candidate sequence d: 2, 3, 5, 7, 9, 11, ... (odd numbers from 3).
//  Latency: T trials take T*(N_W+2) cycles. done is high in cycle T*(N_W+2)+1 after the accept edge.
//   Invalid n: done is in cycle 1, with T=0, invalid=1, p=0, q=n.
//  p, q, prime, invalid and trials update only in FIN. They hold until the next FIN or reset.
//  start while busy: ignored, never queued. start and abort in the same IDLE cycle: start wins.
//  abort while busy: -> IDLE next cycle. No done pulse. Outputs keep previous values.
//  Reset mid-operation: immediate return to the reset state, including the divider.
//  Arithmetic: d is N_W bits and never exceeds 2^ceil(N_W/2)+4, so it does not overflow.
//   trials saturates at all-ones.
// CONFIGURATION
//  WHEEL6_EN defined: sequence is 2, 3, then 6k+-1 (5, 7, 11, 13, 17, 19, 23, 25, ...).
//   Step alternates +2 and +4 from 5. p, q and prime are identical; trials and latency are lower.
//  WHEEL6_EN undefined: the odd-step sequence above. The step toggle flop is absent.
// STRUCTURE
//  Package rsa_pkg holds:
//   - FSM state encoding
//   - default N_W and CNT_W
//   - FIRST_ODD=3 and the wheel step constants
//  Sub-module serial_divmod (N_W) takes dividend, divisor, load and step.
//   It returns quo, rem and fin after N_W steps. Reused by the decryptor.
//  Top level: FSM, candidate generator, trial counter, result registers.
// TESTING  (N_W=14)
//  n=15 -> d=2, then 3 divides: p=3, q=5, prime=0, trials=2, done at cycle 33.
//  n=143 -> p=11, q=13. trials=6 without WHEEL6_EN, 5 with it.
//  n=127 -> prime=1, p=1, q=127. trials=7 without WHEEL6_EN, 6 with it. n=4 -> p=2, q=2, trials=1.
//  n=1 -> invalid=1, done at cycle 1, trials=0. Then n=0 behaves the same.
//  Start n=16129 (127*127). Pulse start again with n=6 mid-run: ignored.
//   Abort at cycle 40: no done, busy low next cycle. Restart with n=6 -> p=2, q=3.
//  rst_n low during DIV -> all outputs 0 asynchronously. Then a normal n=35 run gives p=5, q=7.

Source files
------------

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared constants and FSM encoding for the RSA factoring path
// Contents: default widths, trial-division candidate constants, factor FSM states.
package rsa_pkg;

  localparam int N_W_DEF   = 14;
  localparam int CNT_W_DEF = 8;

  // Candidate sequence: 2, then odd numbers from FIRST_ODD.
  localparam int FIRST_CAND = 2;
  localparam int FIRST_ODD  = 3;
  localparam int ODD_STEP   = 2;

  // 6k+-1 wheel: after 3 comes WHEEL_START, then +2/+4 alternating.
  localparam int WHEEL_START  = 5;
  localparam int WHEEL_STEP_A = 2;
  localparam int WHEEL_STEP_B = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DIV   = 3'd2,
    ST_CHECK = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/serial_divmod.sv
// rtl/serial_divmod.sv - restoring serial divider, one quotient bit per step
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture dividend/divisor, clear remainder and bit counter
//   step              produce the next quotient bit
//   dividend, divisor N_W-bit operands (divisor must be non-zero)
//   quo, rem          quotient / remainder, valid after N_W steps
//   fin               high during the final (N_W-th) step
module serial_divmod #(
  parameter int N_W = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [N_W-1:0] dividend,
  input  logic [N_W-1:0] divisor,
  output logic [N_W-1:0] quo,
  output logic [N_W-1:0] rem,
  output logic           fin
);

  localparam int CW = $clog2(N_W + 1);

  logic [N_W-1:0] quo_r;
  logic [N_W-1:0] rem_r;
  logic [N_W-1:0] div_r;
  logic [CW-1:0]  cnt;
  logic [N_W:0]   trial;
  logic           ge;
  logic [N_W-1:0] diff;

  // quo_r doubles as the dividend shift register: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  assign trial = {rem_r, quo_r[N_W-1]};
  assign ge    = (trial >= {1'b0, div_r});
  // When ge, trial - div_r < div_r, so the low N_W bits hold the result.
  assign diff  = trial[N_W-1:0] - div_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r <= '0;
      rem_r <= '0;
      div_r <= '0;
      cnt   <= '0;
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= '0;
      div_r <= divisor;
      cnt   <= '0;
    end else if (step) begin
      quo_r <= {quo_r[N_W-2:0], ge};
      rem_r <= ge ? diff : trial[N_W-1:0];
      cnt   <= cnt + CW'(1);
    end
  end

  assign quo = quo_r;
  assign rem = rem_r;
  assign fin = step && (cnt == CW'(N_W - 1));

endmodule

// File: rtl/trial_div_factor.sv
// rtl/trial_div_factor.sv - sequential trial-division factor finder for n = p*q
// Option: WHEEL6_EN selects the 2, 3, 6k+-1 candidate wheel instead of all odd numbers.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request, sampled only while idle; n captured on accept
//   abort       cancel a running search (no done pulse, results kept)
//   n           modulus
//   busy        search in progress
//   done        one-cycle pulse, results valid
//   p, q        smallest factor >= 2 and n/p; 1 and n when n is prime
//   prime       no divisor up to floor(sqrt(n))
//   invalid     n < 2
//   trials      candidates tested, saturating
module trial_div_factor
  import rsa_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_W-1:0]   n,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   p,
  output logic [N_W-1:0]   q,
  output logic             prime,
  output logic             invalid,
  output logic [CNT_W-1:0] trials
);

  state_t           state, state_n;
  logic [N_W-1:0]   n_r;
  logic [N_W-1:0]   d;
  logic [N_W-1:0]   d_next;
  logic [CNT_W-1:0] trial_cnt;
  logic             n_small;
  logic             div_load, div_step, div_fin;
  logic [N_W-1:0]   div_quo, div_rem;
  logic             hit, past_sqrt;

  serial_divmod #(.N_W(N_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (n_r),
    .divisor  (d),
    .quo      (div_quo),
    .rem      (div_rem),
    .fin      (div_fin)
  );

  assign n_small   = (n < N_W'(2));
  assign hit       = (div_rem == '0);
  // quo < d is the same test as d*d > n, without a multiplier.
  assign past_sqrt = (div_quo < d);

`ifdef WHEEL6_EN
  logic step4;

  always_comb begin
    d_next = d + N_W'(ODD_STEP);
    if (d == N_W'(FIRST_CAND))
      d_next = N_W'(FIRST_ODD);
    else if (d == N_W'(FIRST_ODD))
      d_next = N_W'(WHEEL_START);
    else
      d_next = d + (step4 ? N_W'(WHEEL_STEP_B) : N_W'(WHEEL_STEP_A));
  end

  // Toggles only once the wheel is running (d >= 5).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      step4 <= 1'b0;
    else if (state == ST_IDLE && start)
      step4 <= 1'b0;
    else if (state == ST_CHECK && !abort && !hit && !past_sqrt &&
             d != N_W'(FIRST_CAND) && d != N_W'(FIRST_ODD))
      step4 <= ~step4;
  end
`else
  always_comb begin
    d_next = d + N_W'(ODD_STEP);
    if (d == N_W'(FIRST_CAND))
      d_next = N_W'(FIRST_ODD);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start)
          state_n = n_small ? ST_FIN : ST_LOAD;
      end
      ST_LOAD: begin
        div_load = 1'b1;
        state_n  = abort ? ST_IDLE : ST_DIV;
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (abort)
          state_n = ST_IDLE;
        else if (div_fin)
          state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)
          state_n = ST_IDLE;
        else if (hit || past_sqrt)
          state_n = ST_FIN;
        else
          state_n = ST_LOAD;
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_LOAD) || (state == ST_DIV) || (state == ST_CHECK);
  assign done = (state == ST_FIN);

  // Result registers are written on the edge into FIN so they are valid
  // alongside the done pulse and then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r       <= '0;
      d         <= '0;
      trial_cnt <= '0;
      p         <= '0;
      q         <= '0;
      prime     <= 1'b0;
      invalid   <= 1'b0;
      trials    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_r       <= n;
            d         <= N_W'(FIRST_CAND);
            trial_cnt <= '0;
            if (n_small) begin
              p       <= '0;
              q       <= n;
              prime   <= 1'b0;
              invalid <= 1'b1;
              trials  <= '0;
            end
          end
        end
        ST_LOAD: begin
          if (trial_cnt != '1)
            trial_cnt <= trial_cnt + CNT_W'(1);
        end
        ST_CHECK: begin
          if (!abort) begin
            if (hit) begin
              p       <= d;
              q       <= div_quo;
              prime   <= 1'b0;
              invalid <= 1'b0;
              trials  <= trial_cnt;
            end else if (past_sqrt) begin
              p       <= N_W'(1);
              q       <= n_r;
              prime   <= 1'b1;
              invalid <= 1'b0;
              trials  <= trial_cnt;
            end else begin
              d <= d_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trial_div_factor.sv
// tb/tb_trial_div_factor.sv - self-checking bench for trial_div_factor
module tb_trial_div_factor;

  localparam int N_W   = 14;
  localparam int CNT_W = 8;
  localparam int TMO   = 3000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [N_W-1:0]   n = '0;
  logic             busy, done, prime, invalid;
  logic [N_W-1:0]   p, q;
  logic [CNT_W-1:0] trials;

  always #5 clk = ~clk;

  trial_div_factor #(.N_W(N_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .n       (n),
    .busy    (busy),
    .done    (done),
    .p       (p),
    .q       (q),
    .prime   (prime),
    .invalid (invalid),
    .trials  (trials)
  );

  typedef struct {
    int n;
    int p;
    int q;
    int prime;
    int inv;
    int trials;
  } vec_t;

  typedef struct {
    int n;
    int p;
    int q;
    int prime;
    int inv;
    int t_odd;
    int t_wheel;
  } row_t;

`ifdef WHEEL6_EN
  localparam bit WHEEL = 1'b1;
`else
  localparam bit WHEEL = 1'b0;
`endif

  vec_t sb[$];
  vec_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: candidates in the chosen sequence, stop on a divisor or d*d > n.
  function automatic vec_t model(input int nn);
    vec_t v;
    int   d;
    int   t;
    int   inc;
    v.n = nn; v.prime = 0; v.inv = 0; v.p = 0; v.q = nn; v.trials = 0;
    if (nn < 2) begin
      v.inv = 1;
      return v;
    end
    d = 2; t = 0; inc = 2;
    for (int g = 0; g < 200; g++) begin
      t++;
      if (nn % d == 0) begin
        v.p = d; v.q = nn / d;
        break;
      end
      if (d * d > nn) begin
        v.p = 1; v.q = nn; v.prime = 1;
        break;
      end
      if (d == 2) d = 3;
      else if (WHEEL && d == 3) d = 5;
      else if (WHEEL) begin
        d = d + inc;
        inc = 6 - inc;
      end else d = d + 2;
    end
    v.trials = (t > 255) ? 255 : t;
    return v;
  endfunction

  task automatic run_vec(input vec_t e, input string tag);
    vec_t x;
    int   lat;
    bit   got;
    lat = 0; got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    n = N_W'(e.n);
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (k == 1 && e.inv == 0) chk({tag, ".busy_c1"}, int'(busy), 1);
      if (done) begin
        lat = k; got = 1'b1;
        break;
      end
    end
    x = sb.pop_front();
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: no done within %0d cycles expected done", tag, TMO);
      return;
    end
    chk({tag, ".p"},       int'(p),       x.p);
    chk({tag, ".q"},       int'(q),       x.q);
    chk({tag, ".prime"},   int'(prime),   x.prime);
    chk({tag, ".invalid"}, int'(invalid), x.inv);
    chk({tag, ".trials"},  int'(trials),  x.trials);
    chk({tag, ".latency"}, lat, (x.inv != 0) ? 1 : x.trials * (N_W + 2) + 1);
    chk({tag, ".busy_at_done"}, int'(busy), 0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, int'(done), 0);
    last_exp = x;
  endtask

  row_t rows[12];

  initial begin
    vec_t e;
    bit   saw_done;

    rows[0]  = '{15,    3,  5,     0, 0, 2, 2};
    rows[1]  = '{143,   11, 13,    0, 0, 6, 5};
    rows[2]  = '{127,   1,  127,   1, 0, 7, 6};
    rows[3]  = '{4,     2,  2,     0, 0, 1, 1};
    rows[4]  = '{1,     0,  1,     0, 1, 0, 0};
    rows[5]  = '{0,     0,  0,     0, 1, 0, 0};
    rows[6]  = '{2,     2,  1,     0, 0, 1, 1};
    rows[7]  = '{3,     1,  3,     1, 0, 1, 1};
    rows[8]  = '{16383, 3,  5461,  0, 0, 2, 2};
    rows[9]  = '{25,    5,  5,     0, 0, 3, 3};
    rows[10] = '{49,    7,  7,     0, 0, 4, 4};
    rows[11] = '{121,   11, 11,    0, 0, 6, 5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.busy",    int'(busy),    0);
    chk("rst.done",    int'(done),    0);
    chk("rst.p",       int'(p),       0);
    chk("rst.q",       int'(q),       0);
    chk("rst.prime",   int'(prime),   0);
    chk("rst.invalid", int'(invalid), 0);
    chk("rst.trials",  int'(trials),  0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (rows[i]) begin
      e.n = rows[i].n; e.p = rows[i].p; e.q = rows[i].q;
      e.prime = rows[i].prime; e.inv = rows[i].inv;
      e.trials = WHEEL ? rows[i].t_wheel : rows[i].t_odd;
      run_vec(e, $sformatf("vec%0d_n%0d", i, rows[i].n));
    end

    for (int r = 0; r < 6; r++) begin
      e = model(int'($urandom_range(2, 16383)));
      run_vec(e, $sformatf("rnd%0d_n%0d", r, e.n));
    end

    // Long run, ignored restart mid-run, abort in cycle 40
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    n = N_W'(16129);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (k == 5)  begin start = 1'b1; n = N_W'(6); end
      if (k == 6)  start = 1'b0;
      if (k == 39) chk("abort.busy_before", int'(busy), 1);
      if (k == 40) abort = 1'b1;
      if (k == 41) begin
        abort = 1'b0;
        chk("abort.busy_after", int'(busy), 0);
      end
    end
    chk("abort.no_done", int'(saw_done), 0);
    chk("abort.p_held",  int'(p),      last_exp.p);
    chk("abort.q_held",  int'(q),      last_exp.q);
    chk("abort.trials_held", int'(trials), last_exp.trials);
    chk("abort.idle", int'(busy), 0);

    e = '{6, 2, 3, 0, 0, 1};
    run_vec(e, "restart_n6");

    // Asynchronous reset while the divider is running
    @(negedge clk);
    start = 1'b1;
    n = N_W'(35);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy",    int'(busy),    0);
    chk("midrst.done",    int'(done),    0);
    chk("midrst.p",       int'(p),       0);
    chk("midrst.q",       int'(q),       0);
    chk("midrst.prime",   int'(prime),   0);
    chk("midrst.invalid", int'(invalid), 0);
    chk("midrst.trials",  int'(trials),  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    e = '{35, 5, 7, 0, 0, 3};
    run_vec(e, "after_rst_n35");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
